instr_fetch_sequencer: RTL and testbench
========================================

// Module: instr_fetch_sequencer
// PURPOSE
//  Issue side of the opcode/control interface: fetches instructions from instruction ROM,
//  drives OPCODE/OPERAND to the controller, consumes its BRANCH/HALT decisions to form next PC.
//  Owns PC, run/halt state, and a retired-instruction counter; sits between top level and datapath.
// PARAMETERS
//  PC_W     8   PC / instruction-address width
//  INSTR_W  9   instruction width; OPCODE = INSTR[INSTR_W-1 -: 4], OPERAND = INSTR[INSTR_W-5:0]
//  CNT_W    16  retired-instruction counter width
// PORTS
//  CLK         in   1          clock, all state on rising edge
//  RESET       in   1          asynchronous, active-high reset
//  START       in   1          1-cycle pulse: begin execution at START_ADDR
//  START_ADDR  in   PC_W       first instruction address
//  INSTR_IN    in   INSTR_W    ROM data at address PC (combinational ROM read)
//  BRANCH      in   1          from controller: current instruction is a branch
//  BR_COND     in   1          from datapath: branch condition true
//  BR_TARGET   in   PC_W       from datapath: branch target address
//  HALT        in   1          from controller: current instruction is HALT
//  PC          out  PC_W       current instruction address (ROM address)
//  OPCODE      out  4          opcode to controller
//  OPERAND     out  INSTR_W-4  operand field to datapath
//  RUNNING     out  1          state == RUN
//  DONE        out  1          state == HALTED
//  WRAP_ERR    out  1          sticky: PC advanced past 2^PC_W-1
//  INSTR_CNT   out  CNT_W      instructions retired since last START, saturating
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, PC=0, INSTR_CNT=0, WRAP_ERR=0, DONE=0, RUNNING=0.
//  States: IDLE -> RUN on START; RUN -> HALTED when HALT; HALTED -> RUN on START. No other arcs.
//  OPCODE/OPERAND: combinational from INSTR_IN only in RUN; in IDLE/HALTED OPCODE=OP_HALT (4'd12),
//   OPERAND=0, so controller issues no register/memory writes while not running.
//  START in IDLE/HALTED: PC<=START_ADDR, INSTR_CNT<=0, WRAP_ERR<=0, state<=RUN; first instruction
//   presented the cycle after START. START while RUN: ignored.
//  HALT/BRANCH ignored outside RUN (controller decodes forced OP_HALT there).
//  Each RUN cycle retires one instruction (single-cycle CPU); next-PC priority:
//   1) HALT: PC holds, state<=HALTED, INSTR_CNT+1 (HALT counts as retired).
//   2) BRANCH & BR_COND: PC<=BR_TARGET.
//   3) else PC<=PC+1, modulo 2^PC_W; wrap from all-ones to 0 sets WRAP_ERR, execution continues.
//  BRANCH & !BR_COND: sequential PC+1. Branch to own address allowed (tight loop), no special case.
//  INSTR_CNT increments once per RUN cycle, saturates at all-ones, never wraps.
//  HALT & BRANCH same cycle: HALT wins, PC holds.
//  RESET mid-RUN: immediate return to reset values; START in same cycle as RESET ignored.
// STRUCTURE
//  definitions package gains: typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALTED} fetch_state_t;
//   opcode constants OP_HALT=4'd12, OP_BR=4'd10, OP_BREVEN=4'd11 (shared with controller).
//  One sub-module: pc_next_logic (combinational: PC, HALT, BRANCH, BR_COND, BR_TARGET ->
//   next PC, wrap flag); state register, PC, counter, WRAP_ERR live in this module.
// TESTING
//  1 RESET, no START, 10 cycles -> PC=0, OPCODE=12, RUNNING=0, DONE=0, INSTR_CNT=0.
//  2 START_ADDR=8'h10, ROM 10:ADD,11:ADD,12:HALT -> PC 10,11,12 then holds 12; DONE=1 next cycle;
//    INSTR_CNT=3; OPCODE=12 thereafter.
//  3 At PC=8'h20 BRANCH=1,BR_COND=1,BR_TARGET=8'h05 -> PC=8'h05 next cycle; same with BR_COND=0 -> 8'h21.
//  4 HALT=1 and BRANCH=1,BR_COND=1 same cycle -> PC holds, state HALTED, no jump.
//  5 START_ADDR=8'hFE, ROM FE,FF,00 non-branch -> PC FE,FF,00; WRAP_ERR=1 at PC=00, stays 1 until START.
//  6 RESET asserted mid-RUN between edges -> outputs reset immediately; START pulse during RUN ignored;
//    START in HALTED restarts at new START_ADDR with INSTR_CNT=0.

Source files
------------

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer and the controller.
//   fetch_state_t : run/halt state of the fetch sequencer
//   OP_HALT       : opcode forced onto the controller while not running
//   OP_BR         : unconditional/conditional branch opcode
//   OP_BREVEN     : branch-if-even opcode
package instr_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    localparam logic [3:0] OP_HALT   = 4'd12;
    localparam logic [3:0] OP_BR     = 4'd10;
    localparam logic [3:0] OP_BREVEN = 4'd11;

endpackage

// File: rtl/instr_fetch_sequencer_pc_next_logic.sv
// Combinational next-PC selection for the fetch sequencer.
// Ports:
//   pc        in   PC_W  current instruction address
//   halt      in   1     current instruction is HALT
//   branch    in   1     current instruction is a branch
//   br_cond   in   1     branch condition true
//   br_target in   PC_W  branch target address
//   next_pc   out  PC_W  address of the next instruction
//   wrap      out  1     sequential increment rolled over from all-ones to zero
module pc_next_logic #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic            halt,
    input  logic            branch,
    input  logic            br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] next_pc,
    output logic            wrap
);

    logic [PC_W:0] pc_inc;

    // The extra carry bit of the increment is exactly the wrap indication.
    assign pc_inc = {1'b0, pc} + (PC_W + 1)'(1);

    // HALT beats a taken branch, which beats sequential flow; only the
    // sequential path can report a wrap.
    always_comb begin
        next_pc = pc_inc[PC_W-1:0];
        wrap    = pc_inc[PC_W];
        if (halt) begin
            next_pc = pc;
            wrap    = 1'b0;
        end else if (branch && br_cond) begin
            next_pc = br_target;
            wrap    = 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Issue side of the opcode/control interface: owns PC, run/halt state and
// a saturating retired-instruction counter for a single-cycle CPU.
// Ports:
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous active-high reset
//   start      in   1          begin execution at start_addr (IDLE/HALTED only)
//   start_addr in   PC_W       first instruction address
//   instr_in   in   INSTR_W    ROM data at address pc
//   branch     in   1          controller: current instruction is a branch
//   br_cond    in   1          datapath: branch condition true
//   br_target  in   PC_W       datapath: branch target
//   halt       in   1          controller: current instruction is HALT
//   pc         out  PC_W       current instruction address
//   opcode     out  4          opcode to controller (OP_HALT when not running)
//   operand    out  INSTR_W-4  operand to datapath (zero when not running)
//   running    out  1          state is RUN
//   done       out  1          state is HALTED
//   wrap_err   out  1          sticky: PC rolled over past all-ones
//   instr_cnt  out  CNT_W      instructions retired since last start
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               branch,
    input  logic               br_cond,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] operand,
    output logic               running,
    output logic               done,
    output logic               wrap_err,
    output logic [CNT_W-1:0]   instr_cnt
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  pc_seq;
    logic             pc_wrap;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap_err_next;

    pc_next_logic #(
        .PC_W (PC_W)
    ) u_pc_next_logic (
        .pc        (pc),
        .halt      (halt),
        .branch    (branch),
        .br_cond   (br_cond),
        .br_target (br_target),
        .next_pc   (pc_seq),
        .wrap      (pc_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FS_IDLE;
            pc        <= '0;
            instr_cnt <= '0;
            wrap_err  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            instr_cnt <= cnt_next;
            wrap_err  <= wrap_err_next;
        end
    end

    // Outside RUN the controller sees a forced HALT with a zero operand so it
    // never issues writes; controller decisions are only honoured in RUN.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        cnt_next      = instr_cnt;
        wrap_err_next = wrap_err;
        opcode        = OP_HALT;
        operand       = '0;
        running       = 1'b0;
        done          = 1'b0;

        case (state)
            FS_IDLE, FS_HALTED: begin
                done = (state == FS_HALTED);
                if (start) begin
                    state_next    = FS_RUN;
                    pc_next       = start_addr;
                    cnt_next      = '0;
                    wrap_err_next = 1'b0;
                end
            end
            FS_RUN: begin
                running = 1'b1;
                opcode  = instr_in[INSTR_W-1 -: 4];
                operand = instr_in[INSTR_W-5:0];
                pc_next = pc_seq;
                if (instr_cnt != {CNT_W{1'b1}}) begin
                    cnt_next = instr_cnt + CNT_W'(1);
                end
                if (pc_wrap) begin
                    wrap_err_next = 1'b1;
                end
                if (halt) begin
                    state_next = FS_HALTED;
                end
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed self-checking bench for instr_fetch_sequencer. The instruction ROM
// is a bench array read combinationally at the DUT's PC; controller/datapath
// decisions (halt, branch, br_cond, br_target) are driven directly.
module tb_instr_fetch_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] I_ADD  = 9'h023;  // opcode 1, operand 3
    localparam logic [INSTR_W-1:0] I_ADD2 = 9'h045;  // opcode 2, operand 5
    localparam logic [INSTR_W-1:0] I_HALT = 9'h185;  // opcode 12, operand 5

    logic               clk;
    logic               reset;
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               branch;
    logic               br_cond;
    logic [PC_W-1:0]    br_target;
    logic               halt;
    logic [PC_W-1:0]    pc;
    logic [3:0]         opcode;
    logic [INSTR_W-5:0] operand;
    logic               running;
    logic               done;
    logic               wrap_err;
    logic [CNT_W-1:0]   instr_cnt;

    logic [INSTR_W-1:0] rom [256];

    int checks;
    int failures;

    instr_fetch_sequencer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .instr_in   (instr_in),
        .branch     (branch),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .halt       (halt),
        .pc         (pc),
        .opcode     (opcode),
        .operand    (operand),
        .running    (running),
        .done       (done),
        .wrap_err   (wrap_err),
        .instr_cnt  (instr_cnt)
    );

    assign instr_in = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [PC_W-1:0] addr,
                                 input logic br, input logic cond,
                                 input logic [PC_W-1:0] tgt, input logic hlt);
        start      = st;
        start_addr = addr;
        branch     = br;
        br_cond    = cond;
        br_target  = tgt;
        halt       = hlt;
    endtask

    // Advance to just after the next rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) rom[i] = I_ADD;
        rom[8'h11] = I_ADD2;
        rom[8'h12] = I_HALT;

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(2);
        reset = 1'b0;

        // Reset state, idle for 10 cycles
        waitCycles(10);
        checkOutput("idle_pc", 32'(pc), 32'h00);
        checkOutput("idle_opcode", 32'(opcode), 32'd12);
        checkOutput("idle_operand", 32'(operand), 32'd0);
        checkOutput("idle_running", 32'(running), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_cnt", 32'(instr_cnt), 32'd0);

        // Straight-line program ending in HALT
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(1);
        start = 1'b0;
        checkOutput("seq_pc10", 32'(pc), 32'h10);
        checkOutput("seq_running", 32'(running), 32'd1);
        checkOutput("seq_opcode10", 32'(opcode), 32'd1);
        checkOutput("seq_operand10", 32'(operand), 32'd3);
        checkOutput("seq_cnt10", 32'(instr_cnt), 32'd0);
        waitCycles(1);
        checkOutput("seq_pc11", 32'(pc), 32'h11);
        checkOutput("seq_opcode11", 32'(opcode), 32'd2);
        waitCycles(1);
        checkOutput("seq_pc12", 32'(pc), 32'h12);
        checkOutput("seq_opcode12", 32'(opcode), 32'd12);
        checkOutput("seq_operand12", 32'(operand), 32'd5);
        halt = 1'b1;
        waitCycles(1);
        halt = 1'b0;
        checkOutput("halt_pc", 32'(pc), 32'h12);
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_running", 32'(running), 32'd0);
        checkOutput("halt_cnt", 32'(instr_cnt), 32'd3);
        checkOutput("halt_operand", 32'(operand), 32'd0);
        waitCycles(3);
        checkOutput("halt_pc_hold", 32'(pc), 32'h12);
        checkOutput("halt_cnt_hold", 32'(instr_cnt), 32'd3);
        checkOutput("halt_opcode", 32'(opcode), 32'd12);

        // Branches: taken, not taken, branch to self
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(1);
        checkOutput("br_start_pc", 32'(pc), 32'h20);
        checkOutput("br_start_cnt", 32'(instr_cnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b0);
        waitCycles(1);
        checkOutput("br_taken_pc", 32'(pc), 32'h05);
        checkOutput("br_taken_cnt", 32'(instr_cnt), 32'd1);
        br_target = 8'h20;
        waitCycles(1);
        checkOutput("br_back_pc", 32'(pc), 32'h20);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b0);
        waitCycles(1);
        checkOutput("br_not_taken_pc", 32'(pc), 32'h21);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b0);
        waitCycles(1);
        checkOutput("br_self_pc", 32'(pc), 32'h21);
        checkOutput("br_self_cnt", 32'(instr_cnt), 32'd4);

        // HALT and taken branch together: HALT wins
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1);
        waitCycles(1);
        checkOutput("halt_br_pc", 32'(pc), 32'h21);
        checkOutput("halt_br_done", 32'(done), 32'd1);
        checkOutput("halt_br_cnt", 32'(instr_cnt), 32'd5);
        halt = 1'b0;
        waitCycles(1);
        checkOutput("halted_br_ignored_pc", 32'(pc), 32'h21);
        checkOutput("halted_br_ignored_done", 32'(done), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // PC wrap sets sticky WRAP_ERR; START during RUN ignored
        applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(1);
        start = 1'b0;
        checkOutput("wrap_pcFE", 32'(pc), 32'hFE);
        checkOutput("wrap_errFE", 32'(wrap_err), 32'd0);
        waitCycles(1);
        checkOutput("wrap_pcFF", 32'(pc), 32'hFF);
        checkOutput("wrap_errFF", 32'(wrap_err), 32'd0);
        waitCycles(1);
        checkOutput("wrap_pc00", 32'(pc), 32'h00);
        checkOutput("wrap_err00", 32'(wrap_err), 32'd1);
        waitCycles(1);
        checkOutput("wrap_err01", 32'(wrap_err), 32'd1);
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(1);
        start = 1'b0;
        checkOutput("run_start_pc", 32'(pc), 32'h02);
        checkOutput("run_start_cnt", 32'(instr_cnt), 32'd4);
        checkOutput("run_start_wrap", 32'(wrap_err), 32'd1);

        // Restart from HALTED clears counter and WRAP_ERR
        halt = 1'b1;
        waitCycles(1);
        halt = 1'b0;
        checkOutput("rs_halt_wrap", 32'(wrap_err), 32'd1);
        checkOutput("rs_halt_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0);
        waitCycles(1);
        start = 1'b0;
        checkOutput("restart_pc", 32'(pc), 32'h30);
        checkOutput("restart_cnt", 32'(instr_cnt), 32'd0);
        checkOutput("restart_wrap", 32'(wrap_err), 32'd0);
        checkOutput("restart_running", 32'(running), 32'd1);
        waitCycles(1);
        checkOutput("restart_pc31", 32'(pc), 32'h31);
        checkOutput("restart_cnt1", 32'(instr_cnt), 32'd1);

        // Counter saturation: 65540 more retirements from count 1
        waitCycles(65540);
        checkOutput("sat_cnt", 32'(instr_cnt), 32'hFFFF);
        checkOutput("sat_pc", 32'(pc), 32'h35);
        checkOutput("sat_wrap", 32'(wrap_err), 32'd1);

        // Asynchronous reset mid-cycle, with START asserted alongside
        #3;
        reset = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("areset_pc", 32'(pc), 32'h00);
        checkOutput("areset_running", 32'(running), 32'd0);
        checkOutput("areset_done", 32'(done), 32'd0);
        checkOutput("areset_cnt", 32'(instr_cnt), 32'd0);
        checkOutput("areset_wrap", 32'(wrap_err), 32'd0);
        checkOutput("areset_opcode", 32'(opcode), 32'd12);
        waitCycles(1);
        checkOutput("reset_start_running", 32'(running), 32'd0);
        checkOutput("reset_start_pc", 32'(pc), 32'h00);
        reset = 1'b0;
        start = 1'b0;
        waitCycles(1);
        checkOutput("post_reset_running", 32'(running), 32'd0);
        checkOutput("post_reset_pc", 32'(pc), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
